// File: rtl/alu_operand_stage.sv
// ALU operand/destination selection with write-back forwarding, registered behind
// a valid/ready pipeline stage with a one-entry skid buffer.
module alu_operand_stage #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 5,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        b_mode,
    input  logic              dst_sel,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [IMM_W-1:0]  imm,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [REG_AW-1:0] dst_addr
);

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t            state;
    logic              fwd_a;
    logic              fwd_b;
    logic [DATA_W-1:0] rb;
    logic [DATA_W-1:0] new_a;
    logic [DATA_W-1:0] new_b;
    logic [REG_AW-1:0] new_dst;
    logic [DATA_W-1:0] skid_a;
    logic [DATA_W-1:0] skid_b;
    logic [REG_AW-1:0] skid_dst;
    logic              accept;
    logic              consume;

    // Register 0 reads as zero, so a write-back to it must never be forwarded.
    always_comb begin
        fwd_a   = wb_we && (wb_addr == rs_addr) && (rs_addr != '0);
        fwd_b   = wb_we && (wb_addr == rt_addr) && (rt_addr != '0);
        new_a   = fwd_a ? wb_data : rs_data;
        rb      = fwd_b ? wb_data : rt_data;
        new_dst = dst_sel ? rd_addr : rt_addr;
        case (b_mode)
            2'd0:    new_b = rb;
            2'd1:    new_b = {{(DATA_W-IMM_W){1'b0}}, imm};
            2'd2:    new_b = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
            default: new_b = '0;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    // in_ready is registered: it only drops once the skid entry is occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            op_a      <= '0;
            op_b      <= '0;
            dst_addr  <= '0;
            skid_a    <= '0;
            skid_b    <= '0;
            skid_dst  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        op_a      <= new_a;
                        op_b      <= new_b;
                        dst_addr  <= new_dst;
                        out_valid <= 1'b1;
                        state     <= FULL;
                    end
                end
                FULL: begin
                    if (accept && consume) begin
                        op_a     <= new_a;
                        op_b     <= new_b;
                        dst_addr <= new_dst;
                    end else if (accept) begin
                        skid_a   <= new_a;
                        skid_b   <= new_b;
                        skid_dst <= new_dst;
                        in_ready <= 1'b0;
                        state    <= SKID;
                    end else if (consume) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                SKID: begin
                    if (consume) begin
                        op_a     <= skid_a;
                        op_b     <= skid_b;
                        dst_addr <= skid_dst;
                        in_ready <= 1'b1;
                        state    <= FULL;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: expected operations are queued at
// acceptance and popped by a monitor whenever the stage hands one to execute.
module tb_alu_operand_stage;

    localparam int DATA_W = 16;
    localparam int IMM_W  = 5;
    localparam int REG_AW = 5;

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_AW-1:0] d;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        b_mode = '0;
    logic              dst_sel = 1'b0;
    logic [REG_AW-1:0] rs_addr = '0;
    logic [REG_AW-1:0] rt_addr = '0;
    logic [REG_AW-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rs_data = '0;
    logic [DATA_W-1:0] rt_data = '0;
    logic [IMM_W-1:0]  imm = '0;
    logic              wb_we = 1'b0;
    logic [REG_AW-1:0] wb_addr = '0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [REG_AW-1:0] dst_addr;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ready_mode = 2;   // 0 random, 1 hold off, 2 always ready
    bit   jitter_wb = 1'b0;

    alu_operand_stage #(.DATA_W(DATA_W), .IMM_W(IMM_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .b_mode(b_mode), .dst_sel(dst_sel), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rd_addr(rd_addr), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
        .out_ready(out_ready), .op_a(op_a), .op_b(op_b), .dst_addr(dst_addr)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference result of the operation currently on the decode inputs.
    function automatic exp_t model();
        exp_t e;
        int   s;
        e.a = (wb_we && wb_addr == rs_addr && rs_addr != 0) ? wb_data : rs_data;
        s = int'(imm);
        if (s >= (1 << (IMM_W - 1))) s = s - (1 << IMM_W);
        case (b_mode)
            2'd0: e.b = (wb_we && wb_addr == rt_addr && rt_addr != 0) ? wb_data : rt_data;
            2'd1: e.b = DATA_W'(imm);
            2'd2: e.b = DATA_W'(s);
            default: e.b = 0;
        endcase
        e.d = dst_sel ? rd_addr : rt_addr;
        return e;
    endfunction

    task automatic randomize_wb(input bool_bias);
        wb_we   = $urandom_range(0, 3) != 0;
        wb_addr = (bool_bias != 0) ? (($urandom_range(0, 1) != 0) ? rs_addr : rt_addr) : REG_AW'($urandom);
        wb_data = DATA_W'($urandom);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic apply_stimulus(input logic [1:0] m, input logic ds, input logic [REG_AW-1:0] rs,
                                  input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd,
                                  input logic [DATA_W-1:0] rsd, input logic [DATA_W-1:0] rtd,
                                  input logic [IMM_W-1:0] im, input logic we,
                                  input logic [REG_AW-1:0] wa, input logic [DATA_W-1:0] wd);
        int waited = 0;
        b_mode = m; dst_sel = ds; rs_addr = rs; rt_addr = rt; rd_addr = rd;
        rs_data = rsd; rt_data = rtd; imm = im; wb_we = we; wb_addr = wa; wb_data = wd;
        in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
            if (jitter_wb) randomize_wb(1);
        end
        if (!in_ready) begin
            check_output("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            sb_q.push_back(model());
            @(negedge clk);
        end
        in_valid = 1'b0;
        rs_data = DATA_W'($urandom); rt_data = DATA_W'($urandom); imm = IMM_W'($urandom);
        b_mode = 2'($urandom); rs_addr = REG_AW'($urandom); wb_we = 1'($urandom);
    endtask

    task automatic random_op();
        logic [REG_AW-1:0] rs, rt;
        rs = REG_AW'($urandom_range(0, 7));
        rt = REG_AW'($urandom_range(0, 7));
        apply_stimulus(2'($urandom), 1'($urandom), rs, rt, REG_AW'($urandom),
                       DATA_W'($urandom), DATA_W'($urandom), IMM_W'($urandom),
                       $urandom_range(0, 3) != 0,
                       ($urandom_range(0, 1) != 0) ? rs : rt, DATA_W'($urandom));
    endtask

    task automatic wait_drain();
        int n = 0;
        ready_mode = 2;
        while ((sb_q.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("drain_left", 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: decides out_ready for the coming edge and scores each hand-off.
    initial begin
        exp_t e;
        bit held = 1'b0;
        logic [DATA_W-1:0] la, lb;
        logic [REG_AW-1:0] ld;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       out_ready = $urandom_range(0, 2) != 0;
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
            if (!rst_n) begin
                held = 1'b0;
            end else if (out_valid) begin
                if (held) begin
                    check_output("stable_a", 32'(op_a), 32'(la));
                    check_output("stable_d", 32'(dst_addr), 32'(ld));
                    check_output("stable_b", 32'(op_b), 32'(lb));
                end
                held = !out_ready;
                la = op_a; lb = op_b; ld = dst_addr;
                if (out_ready) begin
                    if (sb_q.size() == 0) begin
                        check_output("unexpected_output", 32'(out_valid), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check_output("op_a", 32'(op_a), 32'(e.a));
                        check_output("op_b", 32'(op_b), 32'(e.b));
                        check_output("dst_addr", 32'(dst_addr), 32'(e.d));
                    end
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        exp_t e;
        // Reset with a pending request on the inputs.
        in_valid = 1'b1;
        rs_data = 16'h1234; rt_data = 16'h5678; rd_addr = 5'd9;
        repeat (3) @(negedge clk);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
        check_output("rst_op_a", 32'(op_a), 32'd0);
        check_output("rst_op_b", 32'(op_b), 32'd0);
        check_output("rst_dst", 32'(dst_addr), 32'd0);
        in_valid = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        ready_mode = 2;

        // Immediate extension modes and forwarding corner cases.
        apply_stimulus(2'd1, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0, 16'h0, 5'b10011, 1'b0, 5'd0, 16'h0);
        apply_stimulus(2'd2, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0, 16'h0, 5'b10011, 1'b0, 5'd0, 16'h0);
        apply_stimulus(2'd3, 1'b0, 5'd1, 5'd2, 5'd3, 16'hAAAA, 16'h5555, 5'b10011, 1'b0, 5'd0, 16'h0);
        apply_stimulus(2'd0, 1'b0, 5'd3, 5'd4, 5'd0, 16'h1111, 16'h2222, 5'd0, 1'b1, 5'd3, 16'hBEEF);
        apply_stimulus(2'd0, 1'b1, 5'd0, 5'd6, 5'd7, 16'h0000, 16'h3333, 5'd0, 1'b1, 5'd0, 16'hBEEF);
        apply_stimulus(2'd0, 1'b0, 5'd5, 5'd5, 5'd1, 16'h0101, 16'h0202, 5'd0, 1'b1, 5'd5, 16'hCAFE);
        apply_stimulus(2'd0, 1'b0, 5'd0, 5'd0, 5'd1, 16'h0000, 16'h0000, 5'd0, 1'b1, 5'd0, 16'hFFFF);
        wait_drain();

        // Back-to-back A, B, C with execute stalled: A held, B in skid, C waits.
        ready_mode = 1;
        @(negedge clk);
        apply_stimulus(2'd0, 1'b0, 5'd1, 5'd2, 5'd3, 16'hAAAA, 16'hA0A0, 5'd1, 1'b0, 5'd0, 16'h0);
        apply_stimulus(2'd1, 1'b1, 5'd4, 5'd5, 5'd6, 16'hBBBB, 16'hB0B0, 5'd2, 1'b0, 5'd0, 16'h0);
        fork
            apply_stimulus(2'd2, 1'b0, 5'd7, 5'd8, 5'd9, 16'hCCCC, 16'hC0C0, 5'd31, 1'b0, 5'd0, 16'h0);
            begin
                #1;
                check_output("skid_in_ready", 32'(in_ready), 32'd0);
                check_output("skid_out_valid", 32'(out_valid), 32'd1);
                check_output("skid_head_a", 32'(op_a), 32'hAAAA);
                repeat (2) @(negedge clk);
                #1;
                check_output("skid_c_stalled", 32'(sb_q.size()), 32'd2);
                ready_mode = 2;
            end
        join
        wait_drain();

        // Reset while the skid entry is occupied.
        ready_mode = 1;
        @(negedge clk);
        apply_stimulus(2'd0, 1'b0, 5'd1, 5'd2, 5'd3, 16'h1111, 16'h2222, 5'd0, 1'b0, 5'd0, 16'h0);
        apply_stimulus(2'd0, 1'b0, 5'd4, 5'd5, 5'd6, 16'h4444, 16'h5555, 5'd0, 1'b0, 5'd0, 16'h0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check_output("midrst_out_valid", 32'(out_valid), 32'd0);
        check_output("midrst_in_ready", 32'(in_ready), 32'd1);
        check_output("midrst_op_a", 32'(op_a), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        apply_stimulus(2'd2, 1'b1, 5'd9, 5'd10, 5'd11, 16'h9999, 16'h0, 5'b01111, 1'b0, 5'd0, 16'h0);
        check_output("postrst_latency", 32'(out_valid), 32'd1);
        check_output("postrst_op_a", 32'(op_a), 32'h9999);
        wait_drain();

        // Randomised traffic with random back-pressure and write-back activity.
        ready_mode = 0;
        jitter_wb = 1'b1;
        for (int i = 0; i < 300; i++) begin
            random_op();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        jitter_wb = 1'b0;
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
